// File: rtl/rv32i_fetch_unit.sv
`default_nettype none
// ============================================================================
// rv32i_fetch_unit : credit-based prefetching instruction fetch unit
// Revision: 1.0
// ============================================================================
module rv32i_fetch_unit #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FAULT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];
  logic [XLEN-1:0] fifo_instr_q [DEPTH];
  logic [XLEN-1:0] pend_pc_q    [DEPTH];
  logic [AW-1:0]   fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [AW-1:0]   pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   disc_cnt_q, disc_cnt_d;

  logic w_run, w_credit, w_issue, w_push, w_pop, w_redirect, w_misaligned;

  assign w_run        = (state_q == ST_RUN);
  assign w_credit     = ({1'b0, fifo_cnt_q} + {1'b0, out_cnt_q}) < DEPTH_W;
  assign w_redirect   = redirect_valid && (state_q != ST_FAULT);
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);

  assign imem_req_valid = w_run && w_credit && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign w_issue        = imem_req_valid && imem_req_ready;

  // A redirect wins over everything else that could touch the prefetch FIFO.
  assign w_push   = imem_rsp_valid && (disc_cnt_q == '0) && w_run && !redirect_valid;
  assign if_valid = w_run && (fifo_cnt_q != '0);
  assign w_pop    = if_valid && if_ready && !redirect_valid;

  assign if_instr = if_valid ? fifo_instr_q[fifo_rd_q] : '0;
  assign if_pc    = if_valid ? fifo_pc_q[fifo_rd_q]    : '0;
  assign if_fault = (state_q == ST_FAULT);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    pend_rd_d  = pend_rd_q;
    pend_wr_d  = pend_wr_q;
    disc_cnt_d = disc_cnt_q;

    if (w_issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      pend_wr_d  = pend_wr_q + 1'b1;
    end
    // Every response retires one pending pc, whether kept or dropped.
    if (imem_rsp_valid) begin
      pend_rd_d = pend_rd_q + 1'b1;
      if (disc_cnt_q != '0) disc_cnt_d = disc_cnt_q - 1'b1;
    end
    out_cnt_d = out_cnt_q + CW'(w_issue) - CW'(imem_rsp_valid);

    if (w_push) fifo_wr_d = fifo_wr_q + 1'b1;
    if (w_pop)  fifo_rd_d = fifo_rd_q + 1'b1;
    fifo_cnt_d = fifo_cnt_q + CW'(w_push) - CW'(w_pop);

    unique case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_FAULT;
    endcase

    if (w_redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      fifo_cnt_d = '0;
      disc_cnt_d = out_cnt_q - CW'(imem_rsp_valid);
      if (w_misaligned) state_d = ST_FAULT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_cnt_q <= fifo_cnt_d;
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
    end
  end

  // Storage arrays need no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_issue) pend_pc_q[pend_wr_q] <= fetch_pc_q;
    if (w_push) begin
      fifo_pc_q[fifo_wr_q]    <= pend_pc_q[pend_rd_q];
      fifo_instr_q[fifo_wr_q] <= imem_rsp_data;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(w_push && !w_pop && (fifo_cnt_q == CW'(DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_rv32i_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_rv32i_fetch_unit : phase-table + scoreboard bench for rv32i_fetch_unit
// Revision: 1.0
// ============================================================================
module tb_rv32i_fetch_unit;

  localparam int          XLEN = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_data  = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc    = '0;
  logic            if_valid;
  logic            if_ready = 1'b0;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_fault;

  always #5 clk = ~clk;

  rv32i_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_fault(if_fault)
  );

  typedef struct {
    bit          rst;
    int          n;
    bit          redir;
    logic [31:0] rpc;
    bit          if_rdy;
    bit          req_rdy;
    bit          rnd;
    int          lat;
    int          exp_acc;
    int          exp_pop;
  } phase_t;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } item_t;
  typedef struct { int due; logic [31:0] data; } mrsp_t;

  phase_t      tbl[15];
  item_t       sb[$];
  mrsp_t       memq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ph_acc, ph_pop;
  logic [31:0] exp_pc;
  bit          exp_fault, boot_next, prev_redir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5 ^ {a[15:0], 16'h0000};
  endfunction

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Asserts reset away from a clock edge, checks the asynchronous clear, releases on a negedge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    if_ready       = 1'b0;
    #1;
    chk_bit("rst_req_valid", imem_req_valid, 1'b0);
    chk_bit("rst_if_valid", if_valid, 1'b0);
    chk_bit("rst_if_fault", if_fault, 1'b0);
    chk_word("rst_if_instr", if_instr, 32'h0);
    chk_word("rst_if_pc", if_pc, 32'h0);
    sb.delete();
    memq.delete();
    exp_pc     = RPC;
    exp_fault  = 1'b0;
    boot_next  = 1'b1;
    prev_redir = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock cycle, entered and left on a negedge; the memory model answers in order after lat cycles.
  task automatic run_cycle(input bit redir, input logic [31:0] rpc, input bit ifr,
                           input bit rqr, input int lat);
    item_t it;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if_ready       = ifr;
    imem_req_ready = rqr;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].data;
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (boot_next)  chk_bit("boot_req_valid", imem_req_valid, 1'b0);
    if (prev_redir) chk_bit("flush_if_valid", if_valid, 1'b0);
    chk_bit("if_fault", if_fault, exp_fault);
    if (exp_fault) begin
      chk_bit("fault_req_valid", imem_req_valid, 1'b0);
      chk_bit("fault_if_valid", if_valid, 1'b0);
    end
    if (redir) chk_bit("redir_req_valid", imem_req_valid, 1'b0);

    if (if_valid && ifr && !redir) begin
      ph_pop++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_if_valid if_pc=%h expected=no_instruction", if_pc);
      end else begin
        it = sb.pop_front();
        chk_word("if_pc", if_pc, it.pc);
        chk_word("if_instr", if_instr, it.instr);
      end
    end

    if (imem_req_valid && rqr) begin
      ph_acc++;
      chk_word("req_addr", imem_req_addr, exp_pc);
      memq.push_back('{due: cyc + lat, data: mem_word(imem_req_addr)});
      sb.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end

    if (redir) begin
      sb.delete();
      exp_pc = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) exp_fault = 1'b1;
    end
    prev_redir = redir;
    boot_next  = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    bit ifr, rqr;
    //          rst   n   redir rpc            ifr   rqr   rnd   lat acc pop
    tbl[0]  = '{1'b1,  8, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1,  4,  0};
    tbl[1]  = '{1'b0,  1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1,  0,  1};
    tbl[2]  = '{1'b0,  4, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1,  1,  0};
    tbl[3]  = '{1'b0, 12, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1, -1, -1};
    tbl[4]  = '{1'b1, 10, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1,  9,  7};
    tbl[5]  = '{1'b1,  3, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 3,  2,  0};
    tbl[6]  = '{1'b0, 12, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 3, -1, -1};
    tbl[7]  = '{1'b0, 10, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1, -1, -1};
    tbl[8]  = '{1'b0,  8, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 1, -1, -1};
    tbl[9]  = '{1'b0,  8, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0, 1, -1, -1};
    tbl[10] = '{1'b0,  6, 1'b1, 32'h0000_0102, 1'b1, 1'b1, 1'b0, 1,  0,  0};
    tbl[11] = '{1'b1,  6, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1,  5,  3};
    tbl[12] = '{1'b0, 60, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 2, -1, -1};
    tbl[13] = '{1'b0, 40, 1'b1, 32'h0000_0400, 1'b1, 1'b1, 1'b1, 2, -1, -1};
    tbl[14] = '{1'b0, 20, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1, -1, -1};

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) do_reset();
      ph_acc = 0;
      ph_pop = 0;
      for (int c = 0; c < tbl[i].n; c++) begin
        ifr = tbl[i].rnd ? 1'($urandom_range(0, 1)) : tbl[i].if_rdy;
        rqr = tbl[i].rnd ? 1'($urandom_range(0, 1)) : tbl[i].req_rdy;
        run_cycle(tbl[i].redir && (c == 0), tbl[i].rpc, ifr, rqr, tbl[i].lat);
      end
      if (tbl[i].exp_acc >= 0)
        chk_word($sformatf("p%0d_accepts", i), 32'(ph_acc), 32'(tbl[i].exp_acc));
      if (tbl[i].exp_pop >= 0)
        chk_word($sformatf("p%0d_pops", i), 32'(ph_pop), 32'(tbl[i].exp_pop));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
